io_mmio_ctrl: RTL and testbench
===============================

IO_MMIO_CTRL -- requirements
Module: io_mmio_ctrl

Interface
REQ-001 Parameter NUM_HEX, default 8, number of seven-segment digit outputs (1..8).
REQ-002 Parameter LEDR_W, default 17, red LED bank width (1..32).
REQ-003 Parameter LEDG_W, default 8, green LED bank width (1..32).
REQ-004 Parameter SW_W, default 18, switch input width (1..32).
REQ-005 Parameter NUM_KEY, default 4, push-key count (1..8).
REQ-006 Parameter DEB_CYCLES, default 16, debounce stability count (>=2).
REQ-007 clk_i  in  1  single clock, all state on rising edge.
REQ-008 rst_i  in  1  reset, synchronous, active-high.
REQ-009 req_i  in  1  bus request, sampled every cycle.
REQ-010 we_i  in  1  1 = write, 0 = read.
REQ-011 addr_i  in  12  byte address within the I/O window; bits [1:0] ignored.
REQ-012 wdata_i  in  32  write data.
REQ-013 be_i  in  4  byte enables for writes.
REQ-014 rdata_o  out  32  read data, valid with ack_o.
REQ-015 ack_o  out  1  one-cycle completion strobe.
REQ-016 err_o  out  1  unmapped-address flag, valid with ack_o.
REQ-017 io_sw_i  in  SW_W  raw switches; io_key_i  in  NUM_KEY  raw keys, active-low (0 = pressed).
REQ-018 io_ledr_o  out  LEDR_W; io_ledg_o  out  LEDG_W; io_lcd_o  out  32; io_hex_o  out  NUM_HEX*7  digit i at [7i+6:7i], segments active-low.

Function
REQ-019 The address map SHALL be: 0x000 LEDR (RW), 0x010 LEDG (RW), 0x020+4*i HEX digit i for i<NUM_HEX (RW, bits [6:0]), 0x100 SW (RO), 0x110 KEY level (RO), 0x114 KEY edge (RW, write-1-to-clear), 0x120 LCD (RW).
REQ-020 Every req_i SHALL be accepted; ack_o SHALL assert exactly one cycle after each req_i, so back-to-back requests complete back-to-back.
REQ-021 Writes SHALL update only enabled bytes, take effect on the request cycle's edge, and appear on outputs the following cycle; bits above a register's width SHALL be dropped and read back as 0.
REQ-022 Reads SHALL return the register value sampled on the request cycle, zero-extended.
REQ-023 Unmapped addresses (including HEX i >= NUM_HEX) SHALL ack with err_o=1, rdata_o=0, no state change; writes to RO addresses SHALL ack with err_o=0 and be ignored.
REQ-024 io_sw_i SHALL pass a 2-flop synchronizer; SW reads return the synchronized value (2-cycle input latency).
REQ-025 Each key SHALL pass a 2-flop synchronizer then a debounce counter: counter clears while synced == stable level, increments otherwise; stable level updates when counter reaches DEB_CYCLES-1, counter then clears.
REQ-026 KEY level read SHALL return inverted stable levels (1 = pressed).
REQ-027 A stable 1->0 transition SHALL set the key's edge bit; bits stay set until cleared by writing 1.
REQ-028 A new edge and a W1C on the same bit in the same cycle SHALL leave the bit set.
REQ-029 Glitches shorter than DEB_CYCLES cycles SHALL produce no level change and no edge.

Reset
REQ-030 Under rst_i: LEDR, LEDG, LCD = 0; every HEX digit = 7'h7F (blank); edge bits = 0; debounce counters = 0; stable key levels = 1 (released); synchronizers = 0 for SW, 1 for keys; ack_o = 0, err_o = 0, rdata_o = 0.
REQ-031 A request in flight when rst_i asserts SHALL be dropped (no ack); writes on a reset cycle SHALL be ignored.

Verification
REQ-032 Write 0x0001FFFF be=4'hF to 0x000, read 0x000 -> ack next cycle, rdata_o=0x0001FFFF, io_ledr_o=17'h1FFFF; write be=4'h1 data 0 -> io_ledr_o=17'h1FF00.
REQ-033 Write 0x40 to 0x020+4*3 -> io_hex_o[27:21]=7'h40, other digits 7'h7F; read 0x03C with NUM_HEX=8 -> err_o=0; NUM_HEX=4, access 0x030 -> err_o=1, rdata_o=0.
REQ-034 Hold key0 low 20 cycles (DEB_CYCLES=16) -> KEY level bit0=1, edge bit0=1; 10-cycle low pulse -> no change.
REQ-035 Write 0x1 to 0x114 -> edge bit0 clears; repeat in the same cycle as a new key0 press edge -> bit0 stays 1.
REQ-036 Four consecutive req_i cycles (W,R,W,R) -> four consecutive ack_o pulses, correct data; rst_i asserted in cycle 2 -> no ack for cycle-2 request, all outputs at reset values next cycle.

Source files
------------

// File: rtl/io_mmio_ctrl_if.sv
// Memory-mapped I/O bus: single-cycle request, registered ack/err/rdata one cycle later.
interface io_mmio_ctrl_if;
  logic        req;
  logic        we;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport master (output req, we, addr, wdata, be, input rdata, ack, err);
  modport slave  (input req, we, addr, wdata, be, output rdata, ack, err);
endinterface

// File: rtl/io_mmio_ctrl.sv
// Board I/O register block: LEDs, seven-segment digits, LCD word, synchronized
// switches and debounced keys with sticky write-1-to-clear press flags.
module io_mmio_ctrl #(
  parameter int NUM_HEX    = 8,
  parameter int LEDR_W     = 17,
  parameter int LEDG_W     = 8,
  parameter int SW_W       = 18,
  parameter int NUM_KEY    = 4,
  parameter int DEB_CYCLES = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  io_mmio_ctrl_if.slave        bus,
  input  logic [SW_W-1:0]      io_sw_i,
  input  logic [NUM_KEY-1:0]   io_key_i,
  output logic [LEDR_W-1:0]    io_ledr_o,
  output logic [LEDG_W-1:0]    io_ledg_o,
  output logic [31:0]          io_lcd_o,
  output logic [NUM_HEX*7-1:0] io_hex_o
);

  localparam int               CNT_W    = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [7:0]       HEX_MASK = 8'((1 << NUM_HEX) - 1);

  typedef enum logic [2:0] {
    SEL_NONE, SEL_LEDR, SEL_LEDG, SEL_HEX, SEL_SW, SEL_KEY, SEL_EDGE, SEL_LCD
  } sel_e;

  // Architectural registers
  logic [LEDR_W-1:0]  ledr;
  logic [LEDG_W-1:0]  ledg;
  logic [31:0]        lcd;
  logic [6:0]         hex [NUM_HEX];
  logic [NUM_KEY-1:0] key_edge;

  // Input conditioning
  logic [SW_W-1:0]    sw_meta, sw_sync;
  logic [NUM_KEY-1:0] key_meta, key_sync, key_stable, key_stable_nxt, edge_set, key_clr;
  logic [CNT_W-1:0]   deb_cnt     [NUM_KEY];
  logic [CNT_W-1:0]   deb_cnt_nxt [NUM_KEY];

  // Bus datapath
  sel_e        sel;
  logic [9:0]  word;
  logic [2:0]  hex_idx;
  logic [31:0] cur_val, merged, be_mask;
  logic        wr_en;
  logic        ack_q, err_q;
  logic [31:0] rdata_q;
  logic        unused_addr_lsb;

  assign word            = bus.addr[11:2];
  assign hex_idx         = word[2:0];
  assign wr_en           = bus.req && bus.we;
  assign unused_addr_lsb = ^bus.addr[1:0];

  // NOTE: every variable driven in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    sel = SEL_NONE;
    case (word)
      10'h000: sel = SEL_LEDR;
      10'h004: sel = SEL_LEDG;
      10'h040: sel = SEL_SW;
      10'h044: sel = SEL_KEY;
      10'h045: sel = SEL_EDGE;
      10'h048: sel = SEL_LCD;
      default: if (word[9:3] == 7'h01 && HEX_MASK[hex_idx]) sel = SEL_HEX;
    endcase
  end

  // Current value of the addressed register, zero-extended; doubles as read data.
  always_comb begin
    cur_val = '0;
    case (sel)
      SEL_LEDR: cur_val[LEDR_W-1:0]  = ledr;
      SEL_LEDG: cur_val[LEDG_W-1:0]  = ledg;
      SEL_HEX: begin
        for (int i = 0; i < NUM_HEX; i++)
          if (hex_idx == 3'(i)) cur_val[6:0] = hex[i];
      end
      SEL_SW:   cur_val[SW_W-1:0]    = sw_sync;
      SEL_KEY:  cur_val[NUM_KEY-1:0] = ~key_stable;
      SEL_EDGE: cur_val[NUM_KEY-1:0] = key_edge;
      SEL_LCD:  cur_val              = lcd;
      default:  cur_val              = '0;
    endcase
  end

  for (genvar b = 0; b < 4; b++) begin : g_be
    assign be_mask[8*b +: 8] = {8{bus.be[b]}};
  end

  assign merged  = (bus.wdata & be_mask) | (cur_val & ~be_mask);
  assign key_clr = (wr_en && sel == SEL_EDGE) ? (bus.wdata[NUM_KEY-1:0] & be_mask[NUM_KEY-1:0])
                                              : '0;

  // Debounce: count consecutive cycles where the synced level disagrees with the stable one.
  always_comb begin
    for (int k = 0; k < NUM_KEY; k++) begin
      key_stable_nxt[k] = key_stable[k];
      deb_cnt_nxt[k]    = '0;
      if (key_sync[k] != key_stable[k]) begin
        if (deb_cnt[k] == CNT_MAX) key_stable_nxt[k] = key_sync[k];
        else                       deb_cnt_nxt[k]    = deb_cnt[k] + 1'b1;
      end
    end
  end

  assign edge_set = key_stable & ~key_stable_nxt;

  // NOTE: clocked blocks use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sw_meta    <= '0;
      sw_sync    <= '0;
      key_meta   <= '1;
      key_sync   <= '1;
      key_stable <= '1;
      key_edge   <= '0;
      for (int k = 0; k < NUM_KEY; k++) deb_cnt[k] <= '0;
    end else begin
      sw_meta    <= io_sw_i;
      sw_sync    <= sw_meta;
      key_meta   <= io_key_i;
      key_sync   <= key_meta;
      key_stable <= key_stable_nxt;
      // A fresh press wins over a simultaneous clear.
      key_edge   <= (key_edge & ~key_clr) | edge_set;
      for (int k = 0; k < NUM_KEY; k++) deb_cnt[k] <= deb_cnt_nxt[k];
    end
  end

  // NOTE: the digit array is a handful of flops, not a RAM, so every entry is reset to blank.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ledr <= '0;
      ledg <= '0;
      lcd  <= '0;
      for (int i = 0; i < NUM_HEX; i++) hex[i] <= 7'h7F;
    end else if (wr_en) begin
      case (sel)
        SEL_LEDR: ledr <= merged[LEDR_W-1:0];
        SEL_LEDG: ledg <= merged[LEDG_W-1:0];
        SEL_LCD:  lcd  <= merged;
        SEL_HEX: begin
          for (int i = 0; i < NUM_HEX; i++)
            if (hex_idx == 3'(i)) hex[i] <= merged[6:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= bus.req;
      err_q   <= bus.req && (sel == SEL_NONE);
      rdata_q <= (bus.req && !bus.we) ? cur_val : '0;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.rdata = rdata_q;

  assign io_ledr_o = ledr;
  assign io_ledg_o = ledg;
  assign io_lcd_o  = lcd;

  for (genvar i = 0; i < NUM_HEX; i++) begin : g_hex
    assign io_hex_o[7*i +: 7] = hex[i];
  end

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Directed bench for io_mmio_ctrl: register map, byte enables, debounce/edge flags,
// back-to-back requests and reset during a request.
module tb_io_mmio_ctrl;

  localparam logic [55:0] HEX_BLANK   = '1;
  localparam logic [27:0] HEX_BLANK_4 = '1;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] sw;
  logic [3:0]  key;

  logic [16:0] ledr_a, ledr_b;
  logic [7:0]  ledg_a, ledg_b;
  logic [31:0] lcd_a, lcd_b;
  logic [55:0] hex_a;
  logic [27:0] hex_b;
  logic [55:0] exp_hex;

  int n_checks = 0;
  int n_errors = 0;

  io_mmio_ctrl_if bus_a ();
  io_mmio_ctrl_if bus_b ();

  io_mmio_ctrl #(.NUM_HEX(8), .LEDR_W(17), .LEDG_W(8), .SW_W(18), .NUM_KEY(4), .DEB_CYCLES(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(bus_a.slave), .io_sw_i(sw), .io_key_i(key),
    .io_ledr_o(ledr_a), .io_ledg_o(ledg_a), .io_lcd_o(lcd_a), .io_hex_o(hex_a)
  );

  io_mmio_ctrl #(.NUM_HEX(4), .LEDR_W(17), .LEDG_W(8), .SW_W(18), .NUM_KEY(4), .DEB_CYCLES(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(bus_b.slave), .io_sw_i(sw), .io_key_i(key),
    .io_ledr_o(ledr_b), .io_ledg_o(ledg_b), .io_lcd_o(lcd_b), .io_hex_o(hex_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Callers sit at a negedge; the request is sampled on the next posedge.
  task automatic set_req(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
    bus_a.req = 1'b1; bus_a.we = we; bus_a.addr = addr; bus_a.wdata = wdata; bus_a.be = be;
  endtask

  task automatic idle_a();
    bus_a.req = 1'b0; bus_a.we = 1'b0; bus_a.addr = '0; bus_a.wdata = '0; bus_a.be = '0;
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                    input logic exp_err, input string tag);
    set_req(1'b1, addr, wdata, be);
    @(negedge clk);
    idle_a();
    check({tag, "_ack"}, bus_a.ack, 1);
    check({tag, "_err"}, bus_a.err, exp_err);
  endtask

  task automatic rd(input logic [11:0] addr, input logic [31:0] exp_data, input logic exp_err,
                    input string tag);
    set_req(1'b0, addr, '0, '0);
    @(negedge clk);
    idle_a();
    check({tag, "_ack"}, bus_a.ack, 1);
    check({tag, "_err"}, bus_a.err, exp_err);
    check({tag, "_data"}, bus_a.rdata, exp_data);
  endtask

  task automatic xfer_b(input logic we, input logic [11:0] addr, input logic [31:0] wdata);
    bus_b.req = 1'b1; bus_b.we = we; bus_b.addr = addr; bus_b.wdata = wdata; bus_b.be = 4'hF;
    @(negedge clk);
    bus_b.req = 1'b0; bus_b.we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; sw = '0; key = '1;
    idle_a();
    bus_b.req = 1'b0; bus_b.we = 1'b0; bus_b.addr = '0; bus_b.wdata = '0; bus_b.be = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", bus_a.ack, 0);
    check("rst_err", bus_a.err, 0);
    check("rst_rdata", bus_a.rdata, 0);
    check("rst_ledr", ledr_a, 0);
    check("rst_ledg", ledg_a, 0);
    check("rst_lcd", lcd_a, 0);
    check("rst_hex", hex_a, HEX_BLANK);
    rst = 1'b0;
    @(negedge clk);

    // LEDR full write, partial byte write, address LSBs ignored
    wr(12'h000, 32'h0001FFFF, 4'hF, 1'b0, "ledr_wr");
    check("ledr_out", ledr_a, 17'h1FFFF);
    rd(12'h000, 32'h0001FFFF, 1'b0, "ledr_rd");
    wr(12'h000, 32'h00000000, 4'h1, 1'b0, "ledr_wr_b0");
    check("ledr_out_b0", ledr_a, 17'h1FF00);
    rd(12'h003, 32'h0001FF00, 1'b0, "ledr_rd_lsb");
    wr(12'h000, 32'hFFFFFFFF, 4'hF, 1'b0, "ledr_wr_wide");
    rd(12'h000, 32'h0001FFFF, 1'b0, "ledr_rd_trunc");

    // HEX digit 3, last digit, out-of-range digit
    wr(12'h02C, 32'h00000040, 4'hF, 1'b0, "hex3_wr");
    exp_hex = HEX_BLANK;
    exp_hex[27:21] = 7'h40;
    check("hex3_out", hex_a, exp_hex);
    rd(12'h02C, 32'h00000040, 1'b0, "hex3_rd");
    rd(12'h03C, 32'h0000007F, 1'b0, "hex7_rd");
    wr(12'h040, 32'hFFFFFFFF, 4'hF, 1'b1, "unmap_wr");
    check("unmap_hex", hex_a, exp_hex);
    check("unmap_ledr", ledr_a, 17'h1FFFF);
    rd(12'h040, 32'h00000000, 1'b1, "unmap_rd");

    // NUM_HEX=4 instance
    xfer_b(1'b0, 12'h030, '0);
    check("b_hex4_ack", bus_b.ack, 1);
    check("b_hex4_err", bus_b.err, 1);
    check("b_hex4_rdata", bus_b.rdata, 0);
    xfer_b(1'b1, 12'h030, 32'h00000000);
    check("b_hex4_wr_err", bus_b.err, 1);
    check("b_hex_out", hex_b, HEX_BLANK_4);
    xfer_b(1'b0, 12'h02C, '0);
    check("b_hex3_err", bus_b.err, 0);
    check("b_hex3_rdata", bus_b.rdata, 32'h7F);

    // LEDG truncation and LCD byte enables
    wr(12'h010, 32'h123456AB, 4'h3, 1'b0, "ledg_wr");
    check("ledg_out", ledg_a, 8'hAB);
    rd(12'h010, 32'h000000AB, 1'b0, "ledg_rd");
    wr(12'h120, 32'hDEADBEEF, 4'b1010, 1'b0, "lcd_wr");
    check("lcd_out", lcd_a, 32'hDE00BE00);
    rd(12'h120, 32'hDE00BE00, 1'b0, "lcd_rd");

    // Switches: synchronized, read-only
    sw = 18'h2A5A5;
    repeat (3) @(negedge clk);
    rd(12'h100, 32'h0002A5A5, 1'b0, "sw_rd");
    wr(12'h100, 32'h00000000, 4'hF, 1'b0, "sw_ro_wr");
    rd(12'h100, 32'h0002A5A5, 1'b0, "sw_ro_rd");

    // 10-cycle glitch on key0 must be filtered
    key[0] = 1'b0;
    repeat (10) @(negedge clk);
    key[0] = 1'b1;
    repeat (25) @(negedge clk);
    rd(12'h110, 32'h0, 1'b0, "glitch_lvl");
    rd(12'h114, 32'h0, 1'b0, "glitch_edge");

    // Real press: stable level changes on the 18th edge after the input change
    key[0] = 1'b0;
    repeat (17) @(negedge clk);
    rd(12'h110, 32'h0, 1'b0, "press_lvl_pre");
    rd(12'h110, 32'h1, 1'b0, "press_lvl");
    rd(12'h114, 32'h1, 1'b0, "press_edge");
    wr(12'h114, 32'h00000001, 4'hF, 1'b0, "w1c_wr");
    rd(12'h114, 32'h0, 1'b0, "w1c_edge");
    rd(12'h110, 32'h1, 1'b0, "w1c_lvl");

    // Release, then clear in the exact cycle a new press edge lands
    key[0] = 1'b1;
    repeat (25) @(negedge clk);
    rd(12'h110, 32'h0, 1'b0, "release_lvl");
    rd(12'h114, 32'h0, 1'b0, "release_edge");
    key[0] = 1'b0;
    repeat (17) @(negedge clk);
    wr(12'h114, 32'h00000001, 4'hF, 1'b0, "race_wr");
    rd(12'h114, 32'h1, 1'b0, "race_edge");
    key[0] = 1'b1;
    repeat (25) @(negedge clk);

    // Back-to-back W,R,W,R
    set_req(1'b1, 12'h120, 32'h12345678, 4'hF);
    @(negedge clk);
    check("b2b_ack1", bus_a.ack, 1);
    set_req(1'b0, 12'h120, '0, '0);
    @(negedge clk);
    check("b2b_ack2", bus_a.ack, 1);
    check("b2b_rd2", bus_a.rdata, 32'h12345678);
    set_req(1'b1, 12'h010, 32'h0000005A, 4'hF);
    @(negedge clk);
    check("b2b_ack3", bus_a.ack, 1);
    set_req(1'b0, 12'h010, '0, '0);
    @(negedge clk);
    check("b2b_ack4", bus_a.ack, 1);
    check("b2b_rd4", bus_a.rdata, 32'h0000005A);
    idle_a();
    @(negedge clk);
    check("b2b_idle", bus_a.ack, 0);

    // Reset lands on the second of two consecutive requests
    set_req(1'b1, 12'h000, 32'h00001234, 4'hF);
    @(negedge clk);
    check("rstmid_ack1", bus_a.ack, 1);
    set_req(1'b0, 12'h120, '0, '0);
    rst = 1'b1;
    @(negedge clk);
    idle_a();
    check("rstmid_ack2", bus_a.ack, 0);
    check("rstmid_err", bus_a.err, 0);
    check("rstmid_rdata", bus_a.rdata, 0);
    check("rstmid_ledr", ledr_a, 0);
    check("rstmid_ledg", ledg_a, 0);
    check("rstmid_lcd", lcd_a, 0);
    check("rstmid_hex", hex_a, HEX_BLANK);
    rst = 1'b0;
    @(negedge clk);
    rd(12'h114, 32'h0, 1'b0, "rstmid_edge");
    rd(12'h000, 32'h0, 1'b0, "rstmid_ledr_rd");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
